led_frame_loader: RTL and testbench

Upstream feeder of the HUB75 panel driver's dual-port frame RAM. Accepts a stream of 9-bit RGB333 pixels from the SoC with a valid/ready handshake, packs 6 pixels into one 54-bit RAM line, and drives the RAM write port (`wr`/`addrWrite`/`dataLine`). It also provides a hardware clear-frame command and frame-complete signalling.

---
 rtl/led_pkg.sv | 43 ++++
 rtl/led_gamma3.sv | 11 +
 rtl/led_frame_loader.sv | 139 +++++++++++++
 tb/tb_led_frame_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the HUB75 frame loader: state encoding, pixel/line geometry,
// lane placement of the six pixels inside a RAM line, and the 3-bit gamma table.
package led_pkg;

    localparam int unsigned PIX_W           = 9;
    localparam int unsigned PIX_PER_WORD    = 6;
    localparam int unsigned DATA_W          = PIX_W * PIX_PER_WORD;
    localparam int unsigned FRAME_WORDS_DEF = 3200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_e;

    // LSB position of pixel k within a line; mirrors the panel driver's unpack order.
    function automatic int unsigned lane_lsb(input logic [2:0] k);
        unique case (k)
            3'd0:    return 9;
            3'd1:    return 0;
            3'd2:    return 27;
            3'd3:    return 18;
            3'd4:    return 45;
            default: return 36;
        endcase
    endfunction

    function automatic logic [2:0] gamma3(input logic [2:0] v);
        unique case (v)
            3'd0:    return 3'd0;
            3'd1:    return 3'd0;
            3'd2:    return 3'd1;
            3'd3:    return 3'd1;
            3'd4:    return 3'd2;
            3'd5:    return 3'd3;
            3'd6:    return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/led_gamma3.sv
// Combinational 3-bit to 3-bit gamma lookup for one colour channel.
module led_gamma3
    import led_pkg::*;
(
    input  logic [2:0] i_val,
    output logic [2:0] o_val
);

    assign o_val = gamma3(i_val);

endmodule

// File: rtl/led_frame_loader.sv
// Packs a valid/ready RGB333 pixel stream into 54-bit frame RAM lines, with clear-frame command.
// Optional gamma remap of each channel when LED_FRAME_LOADER_GAMMA_EN is defined.
module led_frame_loader
    import led_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic              i_sof,
    input  logic              i_pix_valid,
    input  logic [PIX_W-1:0]  i_pix_data,
    output logic              o_pix_ready,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr_write,
    output logic [DATA_W-1:0] o_data_line,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [2:0]        LastPix  = 3'(PIX_PER_WORD - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   pack_q, pack_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [PIX_W-1:0]    pix_g;
    logic                pix_accept;

`ifdef LED_FRAME_LOADER_GAMMA_EN
    led_gamma3 u_gamma_r (.i_val(i_pix_data[8:6]), .o_val(pix_g[8:6]));
    led_gamma3 u_gamma_g (.i_val(i_pix_data[5:3]), .o_val(pix_g[5:3]));
    led_gamma3 u_gamma_b (.i_val(i_pix_data[2:0]), .o_val(pix_g[2:0]));
`else
    assign pix_g = i_pix_data;
`endif

    assign pix_accept = (state_q == S_LOAD) && i_pix_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_clear) begin
                    state_d = S_CLEAR;
                    addr_d  = '0;
                    wr_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = '0;
                end else if (i_start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (pix_accept) begin
                    if (i_sof) begin
                        // Resync: drop the partial line and restart at line 0, pixel 0.
                        addr_d                       = '0;
                        pack_d[lane_lsb(3'd0)+:PIX_W] = pix_g;
                        cnt_d                        = 3'd1;
                    end else begin
                        pack_d[lane_lsb(cnt_q)+:PIX_W] = pix_g;
                        if (cnt_q == LastPix) begin
                            state_d = S_WRITE;
                            wr_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = pack_d;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (addr_q == LastAddr) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (addr_q == LastAddr) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    wr_d    = 1'b1;
                    waddr_d = addr_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            pack_q  <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_pix_ready  = (state_q == S_LOAD);
    assign o_wr         = wr_q;
    assign o_addr_write = waddr_q;
    assign o_data_line  = wdata_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_led_frame_loader.sv
// Scoreboard bench for led_frame_loader with a 4-line frame; gamma expectations follow
// LED_FRAME_LOADER_GAMMA_EN.
module tb_led_frame_loader;

    localparam int unsigned FW = 4;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          sof = 1'b0;
    logic          valid = 1'b0;
    logic [8:0]    pdata = '0;
    logic          pix_ready;
    logic          wr;
    logic [AW-1:0] addr_write;
    logic [53:0]   data_line;
    logic          busy;
    logic          frame_done;

    led_frame_loader #(
        .FRAME_WORDS(FW),
        .ADDR_W     (AW)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_clear     (clear),
        .i_sof       (sof),
        .i_pix_valid (valid),
        .i_pix_data  (pdata),
        .o_pix_ready (pix_ready),
        .o_wr        (wr),
        .o_addr_write(addr_write),
        .o_data_line (data_line),
        .o_busy      (busy),
        .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [53:0]   data;
    } wr_t;

    wr_t        sb[$];
    logic [8:0] line_pix[6];
    int         pidx     = 0;
    int         exp_addr = 0;

`ifdef LED_FRAME_LOADER_GAMMA_EN
    localparam logic [2:0] GTAB[8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
    function automatic logic [8:0] gam(input logic [8:0] p);
        return {GTAB[p[8:6]], GTAB[p[5:3]], GTAB[p[2:0]]};
    endfunction
    localparam logic [8:0] GAMMA_PIX_EXP = 9'h0AF;
`else
    function automatic logic [8:0] gam(input logic [8:0] p);
        return p;
    endfunction
    localparam logic [8:0] GAMMA_PIX_EXP = 9'h137;
`endif

    function automatic logic [53:0] pack_line();
        return {line_pix[4], line_pix[5], line_pix[2], line_pix[3], line_pix[0], line_pix[1]};
    endfunction

    // Every write the DUT issues must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && wr) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 64'(addr_write), 64'hFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(addr_write), 64'(e.addr));
                check("wr_data", 64'(data_line), 64'(e.data));
            end
            check("ready_during_wr", 64'(pix_ready), 64'd0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [8:0] p, input logic s);
        bit accepted;
        accepted = 1'b0;
        valid = 1'b1;
        pdata = p;
        sof   = s;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (pix_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end
        end
        sof = 1'b0;
        if (!accepted) begin
            check("pix_accept_timeout", 64'd0, 64'd1);
        end else begin
            if (s) begin
                pidx     = 0;
                exp_addr = 0;
            end
            line_pix[pidx] = gam(p);
            pidx++;
            if (pidx == 6) begin
                wr_t e;
                e.addr = AW'(exp_addr);
                e.data = pack_line();
                sb.push_back(e);
                exp_addr++;
                pidx = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nwr;
        bit  seen;

        // Reset values
        #12;
        check("rst_wr", 64'(wr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(pix_ready), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_addr", 64'(addr_write), 64'd0);
        check("rst_data", 64'(data_line), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", 64'(pix_ready), 64'd0);

        // Full frame; line 0 is the basic pack of pixels 0x001..0x006
        pulse_start();
        for (int i = 1; i <= 24; i++) send_pixel(9'(i), 1'b0);
        check("frame_last_wr", 64'(wr), 64'd1);
        check("frame_last_addr", 64'(addr_write), 64'(FW - 1));
        @(posedge clk);
        #1;
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("frame_done_wr_low", 64'(wr), 64'd0);
        @(posedge clk);
        #1;
        check("frame_done_end", 64'(frame_done), 64'd0);
        check("frame_busy_fall", 64'(busy), 64'd0);
        valid = 1'b1;
        pdata = 9'h1AA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pix25_ready", 64'(pix_ready), 64'd0);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("frame_sb_empty", 64'(sb.size()), 64'd0);

        // Clear wins over a simultaneous start
        for (int i = 0; i < int'(FW); i++) begin
            wr_t e;
            e.addr = AW'(i);
            e.data = '0;
            sb.push_back(e);
        end
        valid = 1'b1;
        pdata = 9'h155;
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        nwr  = 0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                check("clear_done_cycle", 64'(c), 64'(FW));
            end else if (wr) begin
                nwr++;
            end
        end
        check("clear_done_seen", 64'(seen), 64'd1);
        check("clear_wr_count", 64'(nwr), 64'(FW));
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("clear_sb_empty", 64'(sb.size()), 64'd0);
        check("clear_idle", 64'(busy), 64'd0);

        // Resync on sof mid-line
        pulse_start();
        send_pixel(9'h011, 1'b0);
        send_pixel(9'h012, 1'b0);
        send_pixel(9'h013, 1'b0);
        send_pixel(9'h1FF, 1'b1);
        for (int i = 1; i <= 5; i++) send_pixel(9'h020 + 9'(i), 1'b0);
        // Line 1 leads with the gamma probe pixel {4,6,7}
        send_pixel(9'h137, 1'b0);
        for (int i = 1; i <= 5; i++) send_pixel(9'h040 + 9'(i), 1'b0);
        // Four pixels of line 2, then reset
        for (int i = 1; i <= 4; i++) send_pixel(9'h060 + 9'(i), 1'b0);
        check("resync_sb_empty", 64'(sb.size()), 64'd0);
        check("gamma_lane", 64'(data_line[17:9]), 64'(GAMMA_PIX_EXP));
        check("line1_addr", 64'(addr_write), 64'd1);

        rst_n = 1'b0;
        #1;
        check("mrst_wr", 64'(wr), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_ready", 64'(pix_ready), 64'd0);
        check("mrst_done", 64'(frame_done), 64'd0);
        check("mrst_addr", 64'(addr_write), 64'd0);
        check("mrst_data", 64'(data_line), 64'd0);
        pidx     = 0;
        exp_addr = 0;
        valid    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        for (int i = 1; i <= 6; i++) send_pixel(9'h0C0 + 9'(i), 1'b0);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_addr", 64'(addr_write), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
